// File: rtl/seq_pattern_tx.sv
// Serial MSB-first word transmitter with a one-word holding buffer and
// reference counters for the overlapping 010 and 1001 patterns it emits.
module seq_pattern_tx #(
  parameter int   WIDTH      = 8,
  parameter int   LEN_W      = 4,
  parameter int   CNT_W      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             tx_active,
  output logic             last_bit,
  output logic [CNT_W-1:0] cnt_010,
  output logic [CNT_W-1:0] cnt_1001
);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [LEN_W-1:0] r_rem, w_rem_nxt;
  logic [WIDTH-1:0] r_buf_word, w_buf_word_nxt;
  logic [LEN_W-1:0] r_buf_len, w_buf_len_nxt;
  logic             r_buf_full, w_buf_full_nxt;
  logic             r_x, w_x_nxt;
  logic             r_act, w_act_nxt;
  logic             r_last, w_last_nxt;
  logic [2:0]       r_hist, w_hist_nxt;
  logic [1:0]       r_hcnt, w_hcnt_nxt;
  logic [CNT_W-1:0] r_c010, w_c010_nxt;
  logic [CNT_W-1:0] r_c1001, w_c1001_nxt;

  logic             w_acc;
  logic [LEN_W-1:0] w_in_len;
  logic [WIDTH-1:0] w_in_word;
  logic             w_load;
  logic [WIDTH-1:0] w_ld_word;
  logic [LEN_W-1:0] w_ld_len;

  assign w_acc     = in_valid && !r_buf_full;
  assign w_in_len  = (len_in == '0 || len_in > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len_in;
  // Left-align the used bits so the shifter always emits from its top bit.
  assign w_in_word = data_in << (LEN_W'(WIDTH) - w_in_len);

  assign in_ready  = !r_buf_full;
  assign x         = r_x;
  assign tx_active = r_act;
  assign last_bit  = r_last;
  assign cnt_010   = r_c010;
  assign cnt_1001  = r_c1001;

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_rem_nxt      = r_rem;
    w_buf_word_nxt = r_buf_word;
    w_buf_len_nxt  = r_buf_len;
    w_buf_full_nxt = r_buf_full;
    w_x_nxt        = r_x;
    w_act_nxt      = r_act;
    w_last_nxt     = r_last;
    w_load         = 1'b0;
    w_ld_word      = w_in_word;
    w_ld_len       = w_in_len;
    case (r_state)
      S_IDLE: begin
        if (w_acc) w_load = 1'b1;
      end
      S_SHIFT: begin
        if (r_rem != '0) begin
          w_x_nxt     = r_shift[WIDTH-1];
          w_shift_nxt = r_shift << 1;
          w_rem_nxt   = r_rem - LEN_W'(1);
          w_last_nxt  = (r_rem == LEN_W'(1));
          if (w_acc) begin
            w_buf_full_nxt = 1'b1;
            w_buf_word_nxt = w_in_word;
            w_buf_len_nxt  = w_in_len;
          end
        end else if (r_buf_full) begin
          w_load         = 1'b1;
          w_ld_word      = r_buf_word;
          w_ld_len       = r_buf_len;
          w_buf_full_nxt = 1'b0;
        end else if (w_acc) begin
          w_load = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_x_nxt     = IDLE_LEVEL;
          w_act_nxt   = 1'b0;
          w_last_nxt  = 1'b0;
        end
      end
    endcase
    if (w_load) begin
      w_state_nxt = S_SHIFT;
      w_x_nxt     = w_ld_word[WIDTH-1];
      w_shift_nxt = w_ld_word << 1;
      w_rem_nxt   = w_ld_len - LEN_W'(1);
      w_act_nxt   = 1'b1;
      w_last_nxt  = (w_ld_len == LEN_W'(1));
    end
  end

  // History restarts whenever x is idle, so matches never straddle a gap.
  always_comb begin
    w_hist_nxt  = '0;
    w_hcnt_nxt  = '0;
    w_c010_nxt  = r_c010;
    w_c1001_nxt = r_c1001;
    if (r_act) begin
      if (r_hcnt >= 2'd2 && r_hist[1:0] == 2'b01 && !r_x)
        w_c010_nxt = r_c010 + CNT_W'(1);
      if (r_hcnt == 2'd3 && r_hist == 3'b100 && r_x)
        w_c1001_nxt = r_c1001 + CNT_W'(1);
      w_hist_nxt = {r_hist[1:0], r_x};
      w_hcnt_nxt = (r_hcnt == 2'd3) ? 2'd3 : r_hcnt + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_rem      <= '0;
      r_buf_word <= '0;
      r_buf_len  <= '0;
      r_buf_full <= 1'b0;
      r_x        <= IDLE_LEVEL;
      r_act      <= 1'b0;
      r_last     <= 1'b0;
      r_hist     <= '0;
      r_hcnt     <= '0;
      r_c010     <= '0;
      r_c1001    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_rem      <= w_rem_nxt;
      r_buf_word <= w_buf_word_nxt;
      r_buf_len  <= w_buf_len_nxt;
      r_buf_full <= w_buf_full_nxt;
      r_x        <= w_x_nxt;
      r_act      <= w_act_nxt;
      r_last     <= w_last_nxt;
      r_hist     <= w_hist_nxt;
      r_hcnt     <= w_hcnt_nxt;
      r_c010     <= w_c010_nxt;
      r_c1001    <= w_c1001_nxt;
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: a word-queue model checked every cycle against two
// instances (8-bit and 2-bit counters), plus literal checks from the test plan.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] data_in;
  logic [3:0] len_in;
  logic       in_valid;
  logic       rdy_a, x_a, act_a, last_a;
  logic       rdy_b, x_b, act_b, last_b;
  logic [7:0] c010_a, c1001_a;
  logic [1:0] c010_b, c1001_b;

  seq_pattern_tx u_dut_a (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .len_in(len_in),
    .in_valid(in_valid), .in_ready(rdy_a), .x(x_a), .tx_active(act_a),
    .last_bit(last_a), .cnt_010(c010_a), .cnt_1001(c1001_a)
  );

  seq_pattern_tx #(.CNT_W(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .len_in(len_in),
    .in_valid(in_valid), .in_ready(rdy_b), .x(x_b), .tx_active(act_b),
    .last_bit(last_b), .cnt_010(c010_b), .cnt_1001(c1001_b)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Model: queue of accepted words; head is the word currently on x.
  int mq_d[$];
  int mq_l[$];
  int m_pos = 0;
  bit m_str[$];
  int m_c010 = 0;
  int m_c1001 = 0;
  int m_acc = 0;

  function automatic bit m_bit();
    return bit'((mq_d[0] >> (mq_l[0] - 1 - m_pos)) & 1);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        mq_d.delete(); mq_l.delete(); m_str.delete();
        m_pos = 0; m_c010 = 0; m_c1001 = 0;
      end else begin
        bit acc;
        int n;
        int l;
        acc = in_valid && (mq_d.size() < 2);
        if (mq_d.size() > 0) begin
          m_str.push_back(m_bit());
          n = m_str.size();
          if (n >= 3 && m_str[n-3] == 0 && m_str[n-2] == 1 && m_str[n-1] == 0) m_c010++;
          if (n >= 4 && m_str[n-4] == 1 && m_str[n-3] == 0 && m_str[n-2] == 0 && m_str[n-1] == 1)
            m_c1001++;
          m_pos++;
          if (m_pos == mq_l[0]) begin
            void'(mq_d.pop_front()); void'(mq_l.pop_front()); m_pos = 0;
          end
        end else begin
          m_str.delete();
        end
        if (acc) begin
          l = int'(len_in);
          if (l == 0 || l > 8) l = 8;
          mq_d.push_back(int'(data_in)); mq_l.push_back(l);
          m_acc++;
        end
      end
    end
  end

  // Capture of the serial stream from instance A for literal checks.
  logic [63:0] cap_bits = '0;
  logic [63:0] cap_last = '0;
  int          cap_n = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        logic ea, ex, el;
        ea = (mq_d.size() > 0);
        ex = ea ? m_bit() : 1'b0;
        el = ea && (m_pos == mq_l[0] - 1);
        chk("x_a", x_a, ex);            chk("x_b", x_b, ex);
        chk("tx_active_a", act_a, ea);  chk("tx_active_b", act_b, ea);
        chk("last_bit_a", last_a, el);  chk("last_bit_b", last_b, el);
        chk("in_ready_a", rdy_a, mq_d.size() < 2);
        chk("in_ready_b", rdy_b, mq_d.size() < 2);
        chk("cnt_010_a", c010_a, m_c010 % 256);
        chk("cnt_1001_a", c1001_a, m_c1001 % 256);
        chk("cnt_010_b", c010_b, m_c010 % 4);
        chk("cnt_1001_b", c1001_b, m_c1001 % 4);
        if (act_a) begin
          cap_bits = {cap_bits[62:0], x_a};
          cap_last = {cap_last[62:0], last_a};
          cap_n++;
        end
      end
    end
  end

  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic cap_clr();
    cap_bits = '0; cap_last = '0; cap_n = 0;
  endtask

  task automatic send(input logic [7:0] d, input logic [3:0] l);
    int a0;
    int t;
    a0 = m_acc; t = 0;
    data_in = d; len_in = l; in_valid = 1'b1;
    do begin nstep(); t++; end while (m_acc == a0 && t < 50);
    chk("accept", m_acc != a0, 1'b1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) nstep();
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    in_valid = 1'b0;
    do begin nstep(); t++; end while (mq_d.size() != 0 && t < 200);
    chk("drain", mq_d.size() == 0, 1'b1);
    nstep();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset_n = 1'b0;
    nstep();
    reset_n = 1'b1;
    nstep();
    cap_clr();
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; data_in = '0; len_in = '0;
    #12;
    chk("rst_x", x_a, 1'b0);
    chk("rst_active", act_a, 1'b0);
    chk("rst_last", last_a, 1'b0);
    chk("rst_ready", rdy_a, 1'b1);
    chk("rst_cnt010", c010_a, 8'd0);
    chk("rst_cnt1001", c1001_a, 8'd0);
    nstep();
    reset_n = 1'b1;
    nstep();
    cap_clr();

    // Back-to-back words form one 16-bit stream.
    send(8'h29, 4'd8); send(8'h13, 4'd8); wait_idle();
    chk("b2b_nbits", cap_n, 16);
    chk("b2b_bits", cap_bits, 64'h2913);
    chk("b2b_last", cap_last, 64'h0101);
    chk("b2b_cnt010_a", c010_a, 8'd4);
    chk("b2b_cnt1001_a", c1001_a, 8'd2);
    chk("b2b_cnt010_b", c010_b, 2'd0);
    chk("b2b_cnt1001_b", c1001_b, 2'd2);

    // Reset mid-word with a word buffered: both discarded, counters cleared.
    send(8'hFF, 4'd8); send(8'h0F, 4'd8); nstep();
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_x", x_a, 1'b0);
    chk("mid_rst_active", act_a, 1'b0);
    chk("mid_rst_ready", rdy_a, 1'b1);
    chk("mid_rst_cnt010", c010_a, 8'd0);
    chk("mid_rst_cnt1001", c1001_a, 8'd0);
    nstep();
    reset_n = 1'b1;
    nstep();
    cap_clr();
    send(8'h05, 4'd3); wait_idle();
    chk("post_rst_nbits", cap_n, 3);
    chk("post_rst_bits", cap_bits, 64'h5);

    // One idle cycle between 0,1 and 0 breaks the 010 match.
    do_reset();
    send(8'h01, 4'd2); idle(2); send(8'h00, 4'd1); wait_idle();
    chk("gap_nbits", cap_n, 3);
    chk("gap_cnt010", c010_a, 8'd0);
    do_reset();
    send(8'h01, 4'd2); send(8'h00, 4'd1); wait_idle();
    chk("nogap_cnt010", c010_a, 8'd1);

    // Length edge cases.
    do_reset();
    send(8'hA5, 4'd0); wait_idle();
    chk("len0_nbits", cap_n, 8);
    chk("len0_bits", cap_bits, 64'hA5);
    cap_clr();
    send(8'h01, 4'd1); wait_idle();
    chk("len1_nbits", cap_n, 1);
    chk("len1_bits", cap_bits, 64'h1);
    chk("len1_last", cap_last, 64'h1);
    cap_clr();
    send(8'hA5, 4'd15); wait_idle();
    chk("len15_nbits", cap_n, 8);
    chk("len15_bits", cap_bits, 64'hA5);

    // Handshake: four words held valid, none lost or duplicated.
    do_reset();
    send(8'h11, 4'd8); send(8'h22, 4'd8);
    chk("hs_ready_low", rdy_a, 1'b0);
    send(8'h33, 4'd8); send(8'h44, 4'd8); wait_idle();
    chk("hs_nbits", cap_n, 32);
    chk("hs_bits", cap_bits, 64'h11223344);
    chk("hs_last", cap_last, 64'h01010101);

    // Counter wrap: 101010101010 holds five 010 matches.
    do_reset();
    send(8'h2A, 4'd6); send(8'h2A, 4'd6); wait_idle();
    chk("wrap_cnt010_a", c010_a, 8'd5);
    chk("wrap_cnt010_b", c010_b, 2'd1);
    chk("wrap_cnt1001_a", c1001_a, 8'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
